// File: rtl/reg_dump_pkg.sv
// Shared widths, header default and state encodings for the
// register-file dump engine.
`ifndef X_LEN
`define X_LEN 32
`endif

package reg_dump_pkg;

  localparam int         X_LEN_DEF = `X_LEN;
  localparam logic [7:0] HDR_DEF   = 8'hA5;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_HDR  = 3'd1;
  localparam logic [2:0] S_LOAD = 3'd2;
  localparam logic [2:0] S_SEND = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

endpackage

// File: rtl/reg_dump_if.sv
// Byte stream valid/ready link from the dump engine
// to the debug UART or display controller.
interface reg_dump_if;

  logic [7:0] Tx_Data;
  logic       Tx_Valid;
  logic       Tx_Ready;

  modport master (
    output Tx_Data,
    output Tx_Valid,
    input  Tx_Ready
  );

  modport slave (
    input  Tx_Data,
    input  Tx_Valid,
    output Tx_Ready
  );

endinterface

// File: rtl/reg_dump.sv
// Walks x0..x31 over the spare read port and streams a
// header byte followed by each register little-endian.
module reg_dump
  import reg_dump_pkg::*;
#(
  parameter int         X_LEN    = X_LEN_DEF,
  parameter logic [7:0] HDR_BYTE = HDR_DEF
) (
  input  logic             clk_Dump,
  input  logic             rst,
  input  logic             Start,
  output logic [4:0]       R_Addr,
  input  logic [X_LEN-1:0] R_Data,
  reg_dump_if.master       tx,
  output logic             Busy,
  output logic             Done
);

  localparam int NB  = X_LEN / 8;
  localparam int BCW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [BCW-1:0] LAST = BCW'(NB - 1);

  logic [2:0]       state;
  logic [X_LEN-1:0] buf_q;
  logic [BCW-1:0]   cnt;
  logic [X_LEN-1:0] shifted;

  assign shifted = buf_q >> {cnt, 3'b000};

  // Outputs decode from registered state only.
  always_comb begin
    tx.Tx_Data  = 8'h00;
    tx.Tx_Valid = 1'b0;
    Busy        = 1'b0;
    Done        = 1'b0;
    unique case (1'b1)
      state == S_HDR: begin
        tx.Tx_Data  = HDR_BYTE;
        tx.Tx_Valid = 1'b1;
        Busy        = 1'b1;
      end
      state == S_LOAD: begin
        Busy = 1'b1;
      end
      state == S_SEND: begin
        tx.Tx_Data  = shifted[7:0];
        tx.Tx_Valid = 1'b1;
        Busy        = 1'b1;
      end
      state == S_DONE: begin
        Done = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_Dump or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      R_Addr <= 5'd0;
      buf_q  <= '0;
      cnt    <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (Start) state <= S_HDR;
        end
        S_HDR: begin
          if (tx.Tx_Ready) state <= S_LOAD;
        end
        S_LOAD: begin
          buf_q <= R_Data;
          cnt   <= '0;
          state <= S_SEND;
        end
        S_SEND: begin
          if (tx.Tx_Ready) begin
            if (cnt != LAST) begin
              cnt <= cnt + 1'b1;
            end else if (R_Addr == 5'd31) begin
              state <= S_DONE;
            end else begin
              R_Addr <= R_Addr + 5'd1;
              state  <= S_LOAD;
            end
          end
        end
        S_DONE: begin
          R_Addr <= 5'd0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_dump.sv
// Directed bench for reg_dump with a behavioural
// register file on the read port.
module tb_reg_dump;
  import reg_dump_pkg::*;

  logic        clk_Dump = 1'b0;
  logic        rst = 1'b1;
  logic        Start = 1'b0;
  logic [4:0]  R_Addr;
  logic [31:0] R_Data;
  logic        Busy;
  logic        Done;

  reg_dump_if tx();

  logic [31:0] regs [32];
  int vecs = 0;
  int errs = 0;
  logic [7:0] cap_q [$];
  logic [7:0] obs_d [$];
  logic       obs_v [$];
  int done_cyc;

  always #5 clk_Dump = ~clk_Dump;

  assign R_Data = (R_Addr == 5'd0) ? 32'd0 : regs[R_Addr];

  reg_dump dut (
    .clk_Dump (clk_Dump),
    .rst      (rst),
    .Start    (Start),
    .R_Addr   (R_Addr),
    .R_Data   (R_Data),
    .tx       (tx),
    .Busy     (Busy),
    .Done     (Done)
  );

  task automatic rf_reset();
    regs[0] = 32'd0;
    regs[1] = 32'hFFFF_FFFE;
    regs[2] = 32'd3;
    for (int i = 3; i < 32; i++) regs[i] = i;
  endtask

  function automatic logic [7:0] exp_byte(
    input int k, input logic [31:0] x5);
    logic [31:0] v;
    int r;
    int b;
    if (k == 0) return 8'hA5;
    r = (k - 1) / 4;
    b = (k - 1) % 4;
    case (r)
      0:       v = 32'd0;
      1:       v = 32'hFFFF_FFFE;
      2:       v = 32'd3;
      5:       v = x5;
      default: v = r;
    endcase
    return v[8*b +: 8];
  endfunction

  task automatic step();
    @(posedge clk_Dump);
    #1;
  endtask

  task automatic run_frame(
    input int stall_idx, input int stall_n,
    input int wr_idx, input int pulse_at,
    input bit hold);
    int cyc;
    int left;
    bit wrote;
    cyc = 0;
    left = stall_n;
    wrote = 0;
    cap_q.delete();
    obs_d.delete();
    obs_v.delete();
    done_cyc = -1;
    tx.Tx_Ready = 1'b1;
    Start = 1'b1;
    step();
    while (cyc < 1000) begin
      cyc++;
      if (cyc == pulse_at || hold) Start = 1'b1;
      else Start = 1'b0;
      if (wr_idx == cap_q.size() && tx.Tx_Valid && !wrote) begin
        regs[5] = 32'hDEAD_BEEF;
        wrote = 1;
      end
      if (stall_idx == cap_q.size() && left > 0 &&
          (left < stall_n || tx.Tx_Valid)) begin
        tx.Tx_Ready = 1'b0;
        left--;
        obs_d.push_back(tx.Tx_Data);
        obs_v.push_back(tx.Tx_Valid);
      end else begin
        tx.Tx_Ready = 1'b1;
      end
      if (tx.Tx_Valid && tx.Tx_Ready) cap_q.push_back(tx.Tx_Data);
      if (Done) begin
        done_cyc = cyc;
        break;
      end
      step();
    end
    tx.Tx_Ready = 1'b1;
    vecs++;
    if (done_cyc < 0) begin
      errs++;
      $display("FAIL frame_timeout: no Done within 1000 cycles");
    end
  endtask

  task automatic check_bytes(input string nm, input logic [31:0] x5);
    vecs++;
    if (cap_q.size() != 129) begin
      errs++;
      $display("FAIL %s_len: got %0d want 129", nm, cap_q.size());
    end
    for (int k = 0; k < 129; k++) begin
      vecs++;
      if (k >= cap_q.size() || cap_q[k] !== exp_byte(k, x5)) begin
        errs++;
        $display("FAIL %s_byte%0d: got %h want %h", nm, k,
                 (k < cap_q.size()) ? cap_q[k] : 8'hxx,
                 exp_byte(k, x5));
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    vecs += 5;
    if (R_Addr !== 5'd0) begin
      errs++; $display("FAIL rst_addr: got %h want 00", R_Addr);
    end
    if (tx.Tx_Data !== 8'h00) begin
      errs++; $display("FAIL rst_data: got %h want 00", tx.Tx_Data);
    end
    if (tx.Tx_Valid !== 1'b0) begin
      errs++; $display("FAIL rst_valid: got %b want 0", tx.Tx_Valid);
    end
    if (Busy !== 1'b0) begin
      errs++; $display("FAIL rst_busy: got %b want 0", Busy);
    end
    if (Done !== 1'b0) begin
      errs++; $display("FAIL rst_done: got %b want 0", Done);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_full_frame();
    rf_reset();
    run_frame(-1, 0, -1, -1, 1'b0);
    check_bytes("full", 32'd5);
    vecs++;
    if (done_cyc != 162) begin
      errs++; $display("FAIL full_done: got %0d want 162", done_cyc);
    end
    step();
    vecs++;
    if (Busy !== 1'b0 || tx.Tx_Valid !== 1'b0 || Done !== 1'b0) begin
      errs++;
      $display("FAIL full_idle: busy %b valid %b done %b want 000",
               Busy, tx.Tx_Valid, Done);
    end
  endtask

  task automatic test_backpressure();
    rf_reset();
    run_frame(6, 5, -1, -1, 1'b0);
    vecs++;
    if (obs_d.size() != 5) begin
      errs++; $display("FAIL bp_cycles: got %0d want 5", obs_d.size());
    end
    for (int i = 0; i < obs_d.size(); i++) begin
      vecs++;
      if (obs_d[i] !== 8'hFF || obs_v[i] !== 1'b1) begin
        errs++;
        $display("FAIL bp_hold%0d: data %h valid %b want ff 1",
                 i, obs_d[i], obs_v[i]);
      end
    end
    check_bytes("bp", 32'd5);
    vecs++;
    if (done_cyc != 167) begin
      errs++; $display("FAIL bp_done: got %0d want 167", done_cyc);
    end
    step();
  endtask

  task automatic test_snapshot();
    rf_reset();
    run_frame(-1, 0, 22, -1, 1'b0);
    check_bytes("snap1", 32'd5);
    step();
    run_frame(-1, 0, -1, -1, 1'b0);
    check_bytes("snap2", 32'hDEAD_BEEF);
    vecs++;
    if (done_cyc != 162) begin
      errs++; $display("FAIL snap_done: got %0d want 162", done_cyc);
    end
    step();
    rf_reset();
  endtask

  task automatic test_start_busy();
    rf_reset();
    run_frame(-1, 0, -1, 50, 1'b0);
    vecs++;
    if (done_cyc != 162) begin
      errs++; $display("FAIL sb_done: got %0d want 162", done_cyc);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      vecs++;
      if (Busy !== 1'b0 || tx.Tx_Valid !== 1'b0) begin
        errs++;
        $display("FAIL sb_idle%0d: busy %b valid %b want 0 0",
                 i, Busy, tx.Tx_Valid);
      end
    end
  endtask

  task automatic test_start_held();
    rf_reset();
    run_frame(-1, 0, -1, -1, 1'b1);
    check_bytes("held", 32'd5);
    vecs++;
    if (done_cyc != 162) begin
      errs++; $display("FAIL held_done: got %0d want 162", done_cyc);
    end
    step();
    vecs++;
    if (Busy !== 1'b0 || tx.Tx_Valid !== 1'b0 || Done !== 1'b0) begin
      errs++;
      $display("FAIL held_gap: busy %b valid %b done %b want 000",
               Busy, tx.Tx_Valid, Done);
    end
    step();
    vecs++;
    if (tx.Tx_Valid !== 1'b1 || tx.Tx_Data !== 8'hA5 || Busy !== 1'b1) begin
      errs++;
      $display("FAIL held_hdr: valid %b data %h busy %b want 1 a5 1",
               tx.Tx_Valid, tx.Tx_Data, Busy);
    end
    Start = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_async_reset();
    int cnt;
    bit hit;
    rf_reset();
    cnt = 0;
    hit = 0;
    tx.Tx_Ready = 1'b1;
    Start = 1'b1;
    step();
    Start = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      if (cnt == 42 && tx.Tx_Valid) begin
        hit = 1;
        break;
      end
      if (tx.Tx_Valid) cnt++;
      step();
    end
    vecs++;
    if (!hit || R_Addr !== 5'd10) begin
      errs++;
      $display("FAIL ar_reach: hit %b addr %0d want 1 10", hit, R_Addr);
    end
    #2;
    rst = 1'b1;
    #1;
    vecs++;
    if (tx.Tx_Valid !== 1'b0 || Busy !== 1'b0 ||
        R_Addr !== 5'd0 || tx.Tx_Data !== 8'h00) begin
      errs++;
      $display("FAIL ar_imm: valid %b busy %b addr %h data %h want 0 0 00 00",
               tx.Tx_Valid, Busy, R_Addr, tx.Tx_Data);
    end
    step();
    rst = 1'b0;
    step();
    run_frame(-1, 0, -1, -1, 1'b0);
    vecs++;
    if (cap_q.size() == 0 || cap_q[0] !== 8'hA5) begin
      errs++;
      $display("FAIL ar_hdr: got %h want a5",
               (cap_q.size() > 0) ? cap_q[0] : 8'hxx);
    end
    check_bytes("ar", 32'd5);
    step();
  endtask

  initial begin
    tx.Tx_Ready = 1'b1;
    rf_reset();
    test_reset();
    test_full_frame();
    test_backpressure();
    test_snapshot();
    test_start_busy();
    test_start_held();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
